// File: rtl/bigadd_pipe.sv
// Pipelined DW-bit adder/subtractor: one LW-bit lane is resolved per advancing edge,
// so the critical path stays one LW-bit add regardless of DW. Sync strobe rides with the data.
module bigadd_pipe #(
    parameter int DW = 64,
    parameter int LW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_sync,
    input  logic          i_sub,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_r,
    output logic          o_carry,
    output logic          o_ovf,
    output logic          o_sync
);

    localparam int NL = DW / LW;

    generate
        if (LW < 1 || (DW % LW) != 0) begin : g_bad_params
            $error("bigadd_pipe: DW must be a positive multiple of LW");
        end
    endgenerate

    // Stage k inputs (w_*[k]) and registered outputs (r_*[k]), k = 1..NL.
    logic [DW-1:0] w_a    [1:NL];
    logic [DW-1:0] w_b    [1:NL];
    logic [DW-1:0] w_s    [1:NL];
    logic [DW-1:0] w_sn   [1:NL];
    logic          w_c    [1:NL];
    logic          w_sync [1:NL];
    logic          w_vld  [1:NL];
    logic [LW:0]   w_lsum [1:NL];

    logic [DW-1:0] r_a    [1:NL];
    logic [DW-1:0] r_b    [1:NL];
    logic [DW-1:0] r_s    [1:NL];
    logic          r_c    [1:NL];
    logic          r_sync [1:NL];
    logic          r_vld  [1:NL];
    logic          r_fresh;

    // Stage 1 is fed straight from the ports: B is inverted and carry-in is 1 for subtract.
    always_comb begin
        w_a[1]    = i_a;
        w_b[1]    = i_sub ? ~i_b : i_b;
        w_s[1]    = '0;
        w_c[1]    = i_sub;
        w_sync[1] = i_sync;
        w_vld[1]  = 1'b1;
        for (int k = 2; k <= NL; k++) begin
            w_a[k]    = r_a[k-1];
            w_b[k]    = r_b[k-1];
            w_s[k]    = r_s[k-1];
            w_c[k]    = r_c[k-1];
            w_sync[k] = r_sync[k-1];
            w_vld[k]  = r_vld[k-1];
        end
    end

    genvar g;
    generate
        for (g = 1; g <= NL; g++) begin : g_lane
            assign w_lsum[g] = {1'b0, w_a[g][g*LW-1 -: LW]}
                             + {1'b0, w_b[g][g*LW-1 -: LW]}
                             + {{LW{1'b0}}, w_c[g]};
        end
    endgenerate

    always_comb begin
        for (int k = 1; k <= NL; k++) begin
            w_sn[k] = w_s[k];
            w_sn[k][(k-1)*LW +: LW] = w_lsum[k][LW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 1; k <= NL; k++) begin
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_s[k]    <= '0;
                r_c[k]    <= 1'b0;
                r_sync[k] <= 1'b0;
                r_vld[k]  <= 1'b0;
            end
            r_fresh <= 1'b0;
        end else begin
            if (i_ce) begin
                for (int k = 1; k <= NL; k++) begin
                    r_a[k]    <= w_a[k];
                    r_b[k]    <= w_b[k];
                    r_s[k]    <= w_sn[k];
                    r_c[k]    <= w_lsum[k][LW];
                    r_sync[k] <= w_sync[k];
                    r_vld[k]  <= w_vld[k];
                end
            end
            // Marks that the last edge advanced, so a held result never re-fires o_sync.
            r_fresh <= i_ce;
        end
    end

    assign o_r     = r_s[NL];
    assign o_carry = r_c[NL];
    assign o_ovf   = (r_a[NL][DW-1] == r_b[NL][DW-1]) && (r_s[NL][DW-1] != r_a[NL][DW-1]);
    assign o_sync  = r_sync[NL] & r_vld[NL] & r_fresh & i_ce;

endmodule

// File: tb/tb_bigadd_pipe.sv
// Directed bench for bigadd_pipe: a 2-lane (LW=32) and a 4-lane (LW=16) instance share
// the same stimulus; hand-computed vectors plus a cycle model for the streaming/reset runs.
module tb_bigadd_pipe;

    logic        clk = 1'b0;
    logic        i_reset, i_ce, i_sync, i_sub;
    logic [63:0] i_a, i_b;
    logic [63:0] o_r32, o_r16;
    logic        o_carry32, o_ovf32, o_sync32;
    logic        o_carry16, o_ovf16, o_sync16;

    int n_vec = 0;
    int n_err = 0;
    int sync16_cnt = 0;
    logic adv_ok = 1'b0;

    typedef struct packed {
        logic        s;
        logic        c;
        logic        o;
        logic [63:0] r;
    } ent_t;
    ent_t m [4];

    always #5 clk = ~clk;

    bigadd_pipe #(.DW(64), .LW(32)) u_dut32 (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_sub(i_sub),
        .i_a(i_a), .i_b(i_b), .o_r(o_r32), .o_carry(o_carry32), .o_ovf(o_ovf32), .o_sync(o_sync32)
    );

    bigadd_pipe #(.DW(64), .LW(16)) u_dut16 (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_sub(i_sub),
        .i_a(i_a), .i_b(i_b), .o_r(o_r16), .o_carry(o_carry16), .o_ovf(o_ovf16), .o_sync(o_sync16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ev);
        n_vec++;
        assert (obs === ev) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ev);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic ev);
        n_vec++;
        assert (obs === ev) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, ev);
        end
    endtask

    // One clock edge; the reference model follows the documented latency (2 / 4 edges).
    task automatic adv();
        logic [63:0] bb;
        logic [64:0] full;
        ent_t e;
        bb   = i_sub ? ~i_b : i_b;
        full = {1'b0, i_a} + {1'b0, bb} + 65'(i_sub);
        e.s  = i_sync;
        e.r  = full[63:0];
        e.c  = full[64];
        e.o  = (i_a[63] == bb[63]) && (full[63] != i_a[63]);
        @(posedge clk);
        #1;
        if (i_reset) begin
            for (int i = 0; i < 4; i++) m[i] = '0;
            adv_ok = 1'b0;
        end else if (i_ce) begin
            for (int i = 3; i > 0; i--) m[i] = m[i-1];
            m[0] = e;
            adv_ok = 1'b1;
        end else begin
            adv_ok = 1'b0;
        end
        if (o_sync16) sync16_cnt++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_r32"}, o_r32, m[1].r);
        chk1({tag, "_c32"}, o_carry32, m[1].c);
        chk1({tag, "_o32"}, o_ovf32, m[1].o);
        chk1({tag, "_s32"}, o_sync32, adv_ok & m[1].s);
        chk({tag, "_r16"}, o_r16, m[3].r);
        chk1({tag, "_c16"}, o_carry16, m[3].c);
        chk1({tag, "_o16"}, o_ovf16, m[3].o);
        chk1({tag, "_s16"}, o_sync16, adv_ok & m[3].s);
    endtask

    task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic sub, input logic sy,
                      input logic [63:0] er, input logic ec, input logic eo);
        i_a = a; i_b = b; i_sub = sub; i_sync = sy;
        adv();
        i_a = '0; i_b = '0; i_sub = 1'b0; i_sync = 1'b0;
        adv();
        chk({tag, "_r32"}, o_r32, er);
        chk1({tag, "_c32"}, o_carry32, ec);
        chk1({tag, "_o32"}, o_ovf32, eo);
        chk1({tag, "_s32"}, o_sync32, sy);
        adv();
        chk1({tag, "_s32_off"}, o_sync32, 1'b0);
        adv();
        chk({tag, "_r16"}, o_r16, er);
        chk1({tag, "_c16"}, o_carry16, ec);
        chk1({tag, "_o16"}, o_ovf16, eo);
        chk1({tag, "_s16"}, o_sync16, sy);
        adv();
        chk1({tag, "_s16_off"}, o_sync16, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m[i] = '0;
        i_reset = 1'b1; i_ce = 1'b1; i_sync = 1'b0; i_sub = 1'b0;
        i_a = 64'h1234; i_b = 64'h5678;
        adv();
        adv();
        i_reset = 1'b0;
        chk("rst_r32", o_r32, 64'h0);
        chk("rst_r16", o_r16, 64'h0);
        chk1("rst_c32", o_carry32, 1'b0);
        chk1("rst_o16", o_ovf16, 1'b0);
        chk1("rst_s16", o_sync16, 1'b0);

        op("xlane", 64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b1, 64'h0000000100000000, 1'b0, 1'b0);
        op("ripple", 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        op("sub5m7", 64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
        op("sub7m5", 64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0);
        op("ovf_add", 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1);
        op("ovf_sub", 64'h8000000000000000, 64'h1, 1'b1, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1);

        // Streaming with a 3-cycle stall before n=8; junk on the inputs while stalled.
        i_reset = 1'b1;
        adv();
        i_reset = 1'b0;
        sync16_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            if (n == 8) begin
                i_ce = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    i_a = {$urandom, $urandom}; i_b = {$urandom, $urandom};
                    i_sync = 1'b1;
                    adv();
                    check_model("stall");
                end
                i_ce = 1'b1;
            end
            i_a = 64'(n) * 64'h0001000100010001;
            i_b = 64'hFFFF;
            i_sync = (n == 3);
            adv();
            check_model("stream");
            if (o_sync16) chk("sync_payload", o_r16, 64'h0003000300040002);
        end
        i_a = '0; i_b = '0; i_sync = 1'b0;
        for (int d = 0; d < 5; d++) begin
            adv();
            check_model("drain");
            if (o_sync16) chk("sync_payload", o_r16, 64'h0003000300040002);
        end
        chk("sync16_count", 64'(sync16_cnt), 64'd1);

        // Reset while three tagged operations are in flight; the reset-cycle operands are dropped.
        sync16_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            i_a = 64'h1111111111111111 * 64'(n + 1);
            i_b = 64'h2222;
            i_sync = 1'b1;
            adv();
        end
        i_reset = 1'b1;
        i_a = 64'hDEADBEEFDEADBEEF; i_b = 64'h1; i_sync = 1'b1;
        adv();
        i_reset = 1'b0;
        chk("flush_r32", o_r32, 64'h0);
        chk("flush_r16", o_r16, 64'h0);
        chk1("flush_c16", o_carry16, 1'b0);
        chk1("flush_o32", o_ovf32, 1'b0);
        chk1("flush_s32", o_sync32, 1'b0);
        i_a = 64'h123456789ABCDEF0; i_b = 64'h0FEDCBA987654321; i_sync = 1'b0;
        adv();
        check_model("post_rst");
        i_a = '0; i_b = '0;
        adv();
        check_model("post_rst");
        chk("post_rst_r32", o_r32, 64'h2222222222222211);
        adv();
        check_model("post_rst");
        adv();
        check_model("post_rst");
        chk("post_rst_r16", o_r16, 64'h2222222222222211);
        chk1("post_rst_c16", o_carry16, 1'b0);
        adv();
        check_model("post_rst");
        chk("rst_sync_none", 64'(sync16_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
